udc_bus_master: RTL and testbench

Host-side bus initiator for the up/down counter's 8-bit microprocessor-style register port. It accepts single read/write commands on a valid/ready request channel and turns each one into a chip-select / write-strobe / read-strobe cycle on `ncs`, `nwr`, `nrd`, `A1:A0` and the bidirectional `din` bus. It also issues the counter's `start_in` pulse. It sits between the test/system controller and the counter, and drives exactly the pins the counter receives.

---
 rtl/udc_bus_pkg.sv | 30 +++
 rtl/udc_bus_master_if.sv | 26 ++
 rtl/udc_bus_phase_cnt.sv | 33 +++
 rtl/udc_bus_master.sv | 160 ++++++++++++++++
 tb/tb_udc_bus_master.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/udc_bus_pkg.sv
// Shared types and elaboration helpers for the up/down counter host bus initiator.
package udc_bus_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  typedef struct packed {
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } udc_cmd_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic bit phase_len_ok(input int n);
    return n >= 1;
  endfunction

endpackage

// File: rtl/udc_bus_master_if.sv
// Command/response channel between the system controller and the bus initiator.
// Handshake: a command transfers on any rising edge where cmd_valid & cmd_ready are both
// high; rsp_valid is a one-cycle pulse with no back-pressure.
interface udc_bus_master_if;
  import udc_bus_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rd;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;

  modport master (
    output cmd_valid, cmd_rd, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  cmd_valid, cmd_rd, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, busy
  );

endinterface

// File: rtl/udc_bus_phase_cnt.sv
// Loadable down-counter timing each bus phase; done is high while the count sits at zero.
module udc_bus_phase_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/udc_bus_master.sv
// Bus initiator: turns single read/write commands into ncs/nwr/nrd cycles on the
// counter's 8-bit register port, and forwards start_req as a registered start_in pulse.
module udc_bus_master
  import udc_bus_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic                clk,
  input  logic                reset,
  udc_bus_master_if.slave     bus,
  input  logic                start_req,
  output logic                ncs,
  output logic                nwr,
  output logic                nrd,
  output logic                A0,
  output logic                A1,
  output logic                start_in,
  inout  wire  [DATA_W-1:0]   din,
  output state_t              dbg_state
);

  if (!phase_len_ok(SETUP_CYC) || !phase_len_ok(STROBE_CYC) || !phase_len_ok(HOLD_CYC)) begin : g_bad_phase_len
    $error("udc_bus_master: SETUP_CYC, STROBE_CYC and HOLD_CYC must all be >= 1");
  end

  localparam int MAX_LEN = max3(SETUP_CYC, STROBE_CYC, HOLD_CYC);
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  state_t            state_q, state_d;
  udc_cmd_t          cmd_q, cmd_d;
  logic              ncs_q, ncs_d;
  logic              nwr_q, nwr_d;
  logic              nrd_q, nrd_d;
  logic              oe_q, oe_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              start_in_q, start_in_d;

  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_load_val;
  logic              cnt_done;
  logic              cmd_fire;

  udc_bus_phase_cnt #(.W(CNT_W)) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .done     (cnt_done)
  );

  assign cmd_fire = bus.cmd_valid && (state_q == ST_IDLE);

  // Every pin changes on the same edge as the state, so strobes can never move
  // together with ncs: SETUP and HOLD each separate them by at least one cycle.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    ncs_d        = ncs_q;
    nwr_d        = nwr_q;
    nrd_d        = nrd_q;
    oe_d         = oe_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    start_in_d   = start_req;
    cnt_load     = 1'b0;
    cnt_load_val = '0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          cmd_d.rd     = bus.cmd_rd;
          cmd_d.addr   = bus.cmd_addr;
          cmd_d.wdata  = bus.cmd_wdata;
          state_d      = ST_SETUP;
          ncs_d        = 1'b0;
          oe_d         = ~bus.cmd_rd;
          cnt_load     = 1'b1;
          cnt_load_val = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt_done) begin
          state_d      = ST_STROBE;
          nwr_d        = cmd_q.rd;
          nrd_d        = ~cmd_q.rd;
          cnt_load     = 1'b1;
          cnt_load_val = STROBE_LD;
        end
      end
      ST_STROBE: begin
        if (cnt_done) begin
          state_d      = ST_HOLD;
          nwr_d        = 1'b1;
          nrd_d        = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = HOLD_LD;
          if (cmd_q.rd) begin
            rsp_rdata_d = din;
            rsp_valid_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_done) begin
          state_d = ST_IDLE;
          ncs_d   = 1'b1;
          oe_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      ncs_q       <= 1'b1;
      nwr_q       <= 1'b1;
      nrd_q       <= 1'b1;
      oe_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      start_in_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      ncs_q       <= ncs_d;
      nwr_q       <= nwr_d;
      nrd_q       <= nrd_d;
      oe_q        <= oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      start_in_q  <= start_in_d;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  assign ncs       = ncs_q;
  assign nwr       = nwr_q;
  assign nrd       = nrd_q;
  assign A1        = cmd_q.addr[1];
  assign A0        = cmd_q.addr[0];
  assign start_in  = start_in_q;
  assign dbg_state = state_q;

  assign din = oe_q ? cmd_q.wdata : 'z;

endmodule

// File: tb/tb_udc_bus_master.sv
// Directed bench for udc_bus_master: default-timing instance plus a stretched-timing instance.
module tb_udc_bus_master;
  import udc_bus_pkg::*;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Default-parameter instance
  udc_bus_master_if bus0 ();
  logic       start_req0;
  logic       ncs0, nwr0, nrd0, a0_0, a1_0, start_in0;
  wire  [7:0] din0;
  state_t     st0;
  logic       probe0, rd_en0;
  logic [7:0] rd_dat0;

  // A released din reads back as the probe value 0x00; a DUT still driving would collide.
  assign din0 = probe0 ? 8'h00 : ((rd_en0 && !nrd0) ? rd_dat0 : 8'hzz);

  udc_bus_master dut0 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus0),
    .start_req (start_req0),
    .ncs       (ncs0),
    .nwr       (nwr0),
    .nrd       (nrd0),
    .A0        (a0_0),
    .A1        (a1_0),
    .start_in  (start_in0),
    .din       (din0),
    .dbg_state (st0)
  );

  // Stretched-timing instance
  udc_bus_master_if bus1 ();
  logic       start_req1;
  logic       ncs1, nwr1, nrd1, a0_1, a1_1, start_in1;
  wire  [7:0] din1;
  state_t     st1;
  logic       rd_en1;
  logic [7:0] rd_dat1;

  assign din1 = (rd_en1 && !nrd1) ? rd_dat1 : 8'hzz;

  udc_bus_master #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus1),
    .start_req (start_req1),
    .ncs       (ncs1),
    .nwr       (nwr1),
    .nrd       (nrd1),
    .A0        (a0_1),
    .A1        (a1_1),
    .start_in  (start_in1),
    .din       (din1),
    .dbg_state (st1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic probe_din0(input string tag);
    probe0 = 1'b1;
    #1;
    check(tag, din0, 32'h0);
    probe0 = 1'b0;
  endtask

  task automatic set_cmd0(input logic rd, input logic [1:0] addr, input logic [7:0] wdata);
    bus0.cmd_rd    = rd;
    bus0.cmd_addr  = addr;
    bus0.cmd_wdata = wdata;
    bus0.cmd_valid = 1'b1;
  endtask

  initial begin
    reset          = 1'b1;
    start_req0     = 1'b0;
    start_req1     = 1'b0;
    probe0         = 1'b0;
    rd_en0         = 1'b0;
    rd_dat0        = 8'h00;
    rd_en1         = 1'b0;
    rd_dat1        = 8'h00;
    bus0.cmd_valid = 1'b0;
    bus0.cmd_rd    = 1'b0;
    bus0.cmd_addr  = 2'b00;
    bus0.cmd_wdata = 8'h00;
    bus1.cmd_valid = 1'b0;
    bus1.cmd_rd    = 1'b0;
    bus1.cmd_addr  = 2'b00;
    bus1.cmd_wdata = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst ncs", ncs0, 1);
    check("rst nwr", nwr0, 1);
    check("rst nrd", nrd0, 1);
    check("rst addr", {a1_0, a0_0}, 2'b00);
    check("rst start_in", start_in0, 0);
    check("rst cmd_ready", bus0.cmd_ready, 1);
    check("rst busy", bus0.busy, 0);
    check("rst rsp_valid", bus0.rsp_valid, 0);
    check("rst rsp_rdata", bus0.rsp_rdata, 8'h00);
    check("rst state", st0, ST_IDLE);
    check("rst ncs sweep", ncs1, 1);
    probe_din0("rst din released");
    reset = 1'b0;
    @(negedge clk);
    check("post-rst cmd_ready", bus0.cmd_ready, 1);

    // Write 0xA5 to addr 01 with start_req in the handshake cycle
    set_cmd0(1'b0, 2'b01, 8'hA5);
    start_req0 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus0.cmd_valid = 1'b0;
        start_req0     = 1'b0;
      end
      check($sformatf("wr ncs c%0d", c), ncs0, (c <= 4) ? 0 : 1);
      check($sformatf("wr nwr c%0d", c), nwr0, (c == 2 || c == 3) ? 0 : 1);
      check($sformatf("wr nrd c%0d", c), nrd0, 1);
      check($sformatf("wr addr c%0d", c), {a1_0, a0_0}, 2'b01);
      check($sformatf("wr start_in c%0d", c), start_in0, (c == 1) ? 1 : 0);
      check($sformatf("wr rsp_valid c%0d", c), bus0.rsp_valid, 0);
      check($sformatf("wr cmd_ready c%0d", c), bus0.cmd_ready, (c <= 4) ? 0 : 1);
      if (c <= 4) check($sformatf("wr din c%0d", c), din0, 8'hA5);
      else        probe_din0("wr din released");
    end

    // Read addr 10, bench returns 0x3C while nrd is low
    rd_en0  = 1'b1;
    rd_dat0 = 8'h3C;
    set_cmd0(1'b1, 2'b10, 8'hFF);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus0.cmd_valid = 1'b0;
        probe_din0("rd din not driven");
      end
      check($sformatf("rd ncs c%0d", c), ncs0, (c <= 4) ? 0 : 1);
      check($sformatf("rd nrd c%0d", c), nrd0, (c == 2 || c == 3) ? 0 : 1);
      check($sformatf("rd nwr c%0d", c), nwr0, 1);
      check($sformatf("rd addr c%0d", c), {a1_0, a0_0}, 2'b10);
      check($sformatf("rd rsp_valid c%0d", c), bus0.rsp_valid, (c == 4) ? 1 : 0);
      if (c == 2) check("rd state strobe", st0, ST_STROBE);
      if (c == 3) check("rd rdata before capture", bus0.rsp_rdata, 8'h00);
      if (c >= 4) check($sformatf("rd rdata c%0d", c), bus0.rsp_rdata, 8'h3C);
    end

    // Back-to-back: write 0x5A to addr 11, then read addr 00 returning 0xC3
    rd_dat0 = 8'hC3;
    set_cmd0(1'b0, 2'b11, 8'h5A);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) set_cmd0(1'b1, 2'b00, 8'hFF);
      if (c == 6) bus0.cmd_valid = 1'b0;
      check($sformatf("b2b ncs c%0d", c), ncs0, (c <= 4 || (c >= 6 && c <= 9)) ? 0 : 1);
      check($sformatf("b2b nwr c%0d", c), nwr0, (c == 2 || c == 3) ? 0 : 1);
      check($sformatf("b2b nrd c%0d", c), nrd0, (c == 7 || c == 8) ? 0 : 1);
      check($sformatf("b2b rsp_valid c%0d", c), bus0.rsp_valid, (c == 9) ? 1 : 0);
      if (c <= 4) check($sformatf("b2b wr din c%0d", c), din0, 8'h5A);
      if (c <= 4) check($sformatf("b2b wr addr c%0d", c), {a1_0, a0_0}, 2'b11);
      if (c >= 6) check($sformatf("b2b rd addr c%0d", c), {a1_0, a0_0}, 2'b00);
      if (c == 5) check("b2b idle cmd_ready", bus0.cmd_ready, 1);
      if (c == 9) check("b2b rd rdata", bus0.rsp_rdata, 8'hC3);
    end

    // Reset during the STROBE phase of a read
    rd_dat0 = 8'h77;
    set_cmd0(1'b1, 2'b01, 8'hFF);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) bus0.cmd_valid = 1'b0;
      if (c == 2) begin
        check("mid-rst nrd low before", nrd0, 0);
        reset = 1'b1;
      end
      if (c == 3) begin
        check("mid-rst ncs", ncs0, 1);
        check("mid-rst nwr", nwr0, 1);
        check("mid-rst nrd", nrd0, 1);
        check("mid-rst rsp_valid", bus0.rsp_valid, 0);
        check("mid-rst rdata", bus0.rsp_rdata, 8'h00);
        check("mid-rst state", st0, ST_IDLE);
        probe_din0("mid-rst din released");
        reset = 1'b0;
      end
      if (c == 4) begin
        check("post mid-rst cmd_ready", bus0.cmd_ready, 1);
        check("post mid-rst rsp_valid", bus0.rsp_valid, 0);
        check("post mid-rst ncs", ncs0, 1);
      end
    end

    // Stretched timing: SETUP=2, STROBE=3, HOLD=2 read returning 0x96
    rd_en1         = 1'b1;
    rd_dat1        = 8'h96;
    bus1.cmd_rd    = 1'b1;
    bus1.cmd_addr  = 2'b11;
    bus1.cmd_wdata = 8'hFF;
    bus1.cmd_valid = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) bus1.cmd_valid = 1'b0;
      check($sformatf("swp ncs c%0d", c), ncs1, (c <= 7) ? 0 : 1);
      check($sformatf("swp nrd c%0d", c), nrd1, (c >= 3 && c <= 5) ? 0 : 1);
      check($sformatf("swp nwr c%0d", c), nwr1, 1);
      check($sformatf("swp rsp_valid c%0d", c), bus1.rsp_valid, (c == 6) ? 1 : 0);
      check($sformatf("swp busy c%0d", c), bus1.busy, (c <= 7) ? 1 : 0);
      if (c <= 7) check($sformatf("swp addr c%0d", c), {a1_1, a0_1}, 2'b11);
      if (c >= 6) check($sformatf("swp rdata c%0d", c), bus1.rsp_rdata, 8'h96);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
